pipe_memory_stage: RTL and testbench

//  Parametrised Y86-64 pipeline memory (M) stage with configurable word width, depth and access latency.

---
 rtl/pipe_memory_stage.sv | 151 +++++++++++++++
 tb/tb_pipe_memory_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_memory_stage.sv
// rtl/pipe_memory_stage.sv - Y86-64 pipeline memory (M) stage with multi-cycle access stall.
// Optional MEM_ERR_STICKY_EN: the first address error latches and blocks all later accesses until reset.
module pipe_memory_stage #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              M_valid,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        M_dste,
    input  logic [3:0]        M_dstm,
    input  logic [DATA_W-1:0] M_vala,
    input  logic [DATA_W-1:0] M_vale,
    input  logic [1:0]        M_status,
    output logic              m_stall,
    output logic [1:0]        m_status,
    output logic [3:0]        m_icode,
    output logic [3:0]        m_dste,
    output logic [3:0]        m_dstm,
    output logic [DATA_W-1:0] m_vale,
    output logic [DATA_W-1:0] m_valm,
    output logic [DATA_W-1:0] written_mem,
    output logic              memory_block_error
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(LATENCY - 1);
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] written_mem_q;
    logic              sticky_q;

    logic              is_write, is_read, access, addr_err, err_flag, in_range;
    logic              complete, stall_c, do_write;
    logic [DATA_W-1:0] addr;
    logic [AW-1:0]     idx;

    // Decode: ret/popq address through valA, everything else through valE.
    always_comb begin
        is_write = M_icode inside {4'd4, 4'd8, 4'd10};
        is_read  = M_icode inside {4'd5, 4'd9, 4'd11};
        addr     = (M_icode == 4'd9 || M_icode == 4'd11) ? M_vala : M_vale;
        access   = M_valid && (M_status == 2'd0) && (is_write || is_read) && !sticky_q;
        addr_err = access && (addr >= DEPTH_W);
        err_flag = addr_err || (sticky_q && M_valid);
        in_range = access && !addr_err;
        idx      = addr[AW-1:0];
    end

`ifdef MEM_ERR_STICKY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (addr_err) begin
            sticky_q <= 1'b1;
        end
    end
`else
    assign sticky_q = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_range && LATENCY > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            S_WAIT: begin
                // Dropping the access mid-wait is a protocol violation; recover to IDLE.
                if (!in_range || cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        complete = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_range) begin
                    if (LATENCY == 1) complete = 1'b1;
                    else              stall_c  = 1'b1;
                end
            end
            S_WAIT: begin
                if (in_range) begin
                    if (cnt_q == CNT_LAST) complete = 1'b1;
                    else                   stall_c  = 1'b1;
                end
            end
            default: begin
                complete = 1'b0;
                stall_c  = 1'b0;
            end
        endcase
        do_write           = !reset && complete && is_write;
        m_stall            = !reset && stall_c;
        m_status           = reset ? 2'd0 : (err_flag ? 2'd3 : M_status);
        memory_block_error = !reset && err_flag;
        m_icode            = reset ? 4'd0 : M_icode;
        m_dste             = reset ? 4'd0 : M_dste;
        m_dstm             = reset ? 4'd0 : M_dstm;
        m_vale             = reset ? '0 : M_vale;
        m_valm             = (!reset && complete && is_read) ? mem_q[idx] : '0;
        written_mem        = reset ? '0 : written_mem_q;
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem_q[idx] <= M_vala;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            written_mem_q <= '0;
        end else if (do_write) begin
            written_mem_q <= M_vala;
        end
    end
endmodule

// File: tb/tb_pipe_memory_stage.sv
// tb/tb_pipe_memory_stage.sv - transaction-level model check of pipe_memory_stage at LATENCY 1 and 3.
module tb_pipe_memory_stage;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          valid_i  [2];
    logic [3:0]    icode_i  [2];
    logic [3:0]    dste_i   [2];
    logic [3:0]    dstm_i   [2];
    logic [DW-1:0] vala_i   [2];
    logic [DW-1:0] vale_i   [2];
    logic [1:0]    status_i [2];
    logic          stall_o  [2];
    logic [1:0]    mstat_o  [2];
    logic [3:0]    micode_o [2];
    logic [3:0]    mdste_o  [2];
    logic [3:0]    mdstm_o  [2];
    logic [DW-1:0] mvale_o  [2];
    logic [DW-1:0] valm_o   [2];
    logic [DW-1:0] wm_o     [2];
    logic          err_o    [2];

    pipe_memory_stage #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset), .M_valid(valid_i[0]), .M_icode(icode_i[0]),
        .M_dste(dste_i[0]), .M_dstm(dstm_i[0]), .M_vala(vala_i[0]), .M_vale(vale_i[0]),
        .M_status(status_i[0]), .m_stall(stall_o[0]), .m_status(mstat_o[0]), .m_icode(micode_o[0]),
        .m_dste(mdste_o[0]), .m_dstm(mdstm_o[0]), .m_vale(mvale_o[0]), .m_valm(valm_o[0]),
        .written_mem(wm_o[0]), .memory_block_error(err_o[0]));

    pipe_memory_stage #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clock(clock), .reset(reset), .M_valid(valid_i[1]), .M_icode(icode_i[1]),
        .M_dste(dste_i[1]), .M_dstm(dstm_i[1]), .M_vala(vala_i[1]), .M_vale(vale_i[1]),
        .M_status(status_i[1]), .m_stall(stall_o[1]), .m_status(mstat_o[1]), .m_icode(micode_o[1]),
        .m_dste(mdste_o[1]), .m_dstm(mdstm_o[1]), .m_vale(mvale_o[1]), .m_valm(valm_o[1]),
        .written_mem(wm_o[1]), .memory_block_error(err_o[1]));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic          exp_stall  [2];
    logic [1:0]    exp_status [2];
    logic [DW-1:0] exp_valm   [2];
    logic          exp_err    [2];
    logic [DW-1:0] mdl_wm     [2];
    logic [DW-1:0] mdl_mem    [2][DEPTH];
    bit            mdl_sticky [2];

    logic [2:0]    cap_stall;
    logic [DW-1:0] cap_valm, cap_wm;
    logic [1:0]    cap_status;
    logic          cap_err;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    chk("rst_stall", d, 64'(stall_o[d]), 64'd0);
                    chk("rst_status", d, 64'(mstat_o[d]), 64'd0);
                    chk("rst_err", d, 64'(err_o[d]), 64'd0);
                    chk("rst_valm", d, valm_o[d], 64'd0);
                    chk("rst_wm", d, wm_o[d], 64'd0);
                    chk("rst_icode", d, 64'(micode_o[d]), 64'd0);
                    chk("rst_vale", d, mvale_o[d], 64'd0);
                end else begin
                    chk("stall", d, 64'(stall_o[d]), 64'(exp_stall[d]));
                    chk("status", d, 64'(mstat_o[d]), 64'(exp_status[d]));
                    chk("err", d, 64'(err_o[d]), 64'(exp_err[d]));
                    chk("valm", d, valm_o[d], exp_valm[d]);
                    chk("wm", d, wm_o[d], mdl_wm[d]);
                    chk("icode", d, 64'(micode_o[d]), 64'(icode_i[d]));
                    chk("dste", d, 64'(mdste_o[d]), 64'(dste_i[d]));
                    chk("dstm", d, 64'(mdstm_o[d]), 64'(dstm_i[d]));
                    chk("vale", d, mvale_o[d], vale_i[d]);
                end
            end
        end
    end

    task automatic set_bubble(input int d);
        valid_i[d] = 1'b0; icode_i[d] = 4'd0; dste_i[d] = 4'd0; dstm_i[d] = 4'd0;
        vala_i[d] = '0; vale_i[d] = '0; status_i[d] = 2'd0;
        exp_stall[d] = 1'b0; exp_status[d] = 2'd0; exp_valm[d] = '0; exp_err[d] = 1'b0;
    endtask

    // Hold one instruction for as many cycles as the model says the access takes.
    task automatic run(input int d, input logic v, input logic [3:0] ic,
                       input logic [63:0] va, input logic [63:0] ve, input logic [1:0] st);
        bit wr, rd;
        logic [63:0] a;
        int n;
        wr = ic inside {4'd4, 4'd8, 4'd10};
        rd = ic inside {4'd5, 4'd9, 4'd11};
        a  = (ic == 4'd9 || ic == 4'd11) ? va : ve;
        valid_i[d] = v; icode_i[d] = ic; dste_i[d] = ic ^ 4'h3; dstm_i[d] = ~ic;
        vala_i[d] = va; vale_i[d] = ve; status_i[d] = st;
        exp_status[d] = st; exp_err[d] = 1'b0;
        if (v && mdl_sticky[d]) begin
            exp_status[d] = 2'd3; exp_err[d] = 1'b1; wr = 0; rd = 0;
        end else if (!v || st != 2'd0) begin
            wr = 0; rd = 0;
        end else if ((wr || rd) && a >= DEPTH) begin
            exp_status[d] = 2'd3; exp_err[d] = 1'b1; wr = 0; rd = 0;
`ifdef MEM_ERR_STICKY_EN
            mdl_sticky[d] = 1'b1;
`endif
        end
        n = ((wr || rd) && d == 1) ? 3 : 1;
        cap_stall = 3'b000;
        for (int k = 0; k < n; k++) begin
            exp_stall[d] = (k < n - 1);
            exp_valm[d]  = (rd && k == n - 1) ? mdl_mem[d][a[9:0]] : 64'd0;
            @(negedge clock);
            cap_stall[k] = stall_o[d];
            cap_valm = valm_o[d]; cap_wm = wm_o[d]; cap_status = mstat_o[d]; cap_err = err_o[d];
            @(posedge clock); #1;
        end
        if (wr) begin
            mdl_mem[d][a[9:0]] = va;
            mdl_wm[d] = va;
        end
        set_bubble(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_bubble(0); set_bubble(1);
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        mdl_wm[0] = '0; mdl_wm[1] = '0;
        mdl_sticky[0] = 1'b0; mdl_sticky[1] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_bubble(0); set_bubble(1);
        mdl_wm[0] = '0; mdl_wm[1] = '0;
        mdl_sticky[0] = 1'b0; mdl_sticky[1] = 1'b0;
        @(posedge clock); #1;
        chk_en = 1'b1;
        do_reset();

        // LATENCY=1 write then read back
        run(0, 1, 4'd4, 64'hDEAD, 64'd16, 2'd0);
        chk("t1_wr_stall", 0, 64'(cap_stall[0]), 64'd0);
        run(0, 0, 4'd0, 64'd0, 64'd0, 2'd0);
        chk("t1_wm", 0, cap_wm, 64'hDEAD);
        run(0, 1, 4'd5, 64'd0, 64'd16, 2'd0);
        chk("t1_valm", 0, cap_valm, 64'hDEAD);

        // LATENCY=3 pushq / popq and call / ret
        run(1, 1, 4'd10, 64'd5, 64'd8, 2'd0);
        chk("t2_push_stalls", 1, 64'(cap_stall), 64'b011);
        run(1, 1, 4'd11, 64'd8, 64'd0, 2'd0);
        chk("t2_pop_valm", 1, cap_valm, 64'd5);
        chk("t2_pop_stalls", 1, 64'(cap_stall), 64'b011);
        run(1, 1, 4'd8, 64'h1234, 64'd30, 2'd0);
        run(1, 1, 4'd9, 64'd30, 64'd0, 2'd0);
        chk("t2_ret_valm", 1, cap_valm, 64'h1234);

        // Non-memory op and status-carrying bubble
        run(0, 1, 4'd6, 64'd3, 64'd3, 2'd0);
        chk("opq_valm", 0, cap_valm, 64'd0);
        run(0, 0, 4'd0, 64'd0, 64'd0, 2'd1);
        chk("bubble_status", 0, 64'(cap_status), 64'd1);

        // Preloads, then a non-AOK write must be suppressed
        run(0, 1, 4'd4, 64'h44, 64'd4, 2'd0);
        run(0, 1, 4'd4, 64'h22, 64'd2, 2'd0);
        run(1, 1, 4'd4, 64'h55, 64'd20, 2'd0);
        run(0, 1, 4'd4, 64'd7, 64'd4, 2'd2);
        chk("t4_status", 0, 64'(cap_status), 64'd2);
        run(0, 1, 4'd5, 64'd0, 64'd4, 2'd0);
        chk("t4_mem_kept", 0, cap_valm, 64'h44);

        // Reset in the middle of a LATENCY=3 write
        valid_i[1] = 1'b1; icode_i[1] = 4'd4; dste_i[1] = 4'd7; dstm_i[1] = 4'd11;
        vala_i[1] = 64'h99; vale_i[1] = 64'd20; status_i[1] = 2'd0;
        exp_stall[1] = 1'b1; exp_status[1] = 2'd0; exp_valm[1] = '0; exp_err[1] = 1'b0;
        @(negedge clock);
        chk("t5_stall0", 1, 64'(stall_o[1]), 64'd1);
        @(posedge clock); #1;
        do_reset();
        run(1, 0, 4'd0, 64'd0, 64'd0, 2'd0);
        chk("t5_stall_after", 1, 64'(cap_stall[0]), 64'd0);
        chk("t5_wm", 1, cap_wm, 64'd0);
        run(1, 1, 4'd5, 64'd0, 64'd20, 2'd0);
        chk("t5_mem_kept", 1, cap_valm, 64'h55);

        // Out-of-range accesses
        run(0, 1, 4'd5, 64'd0, 64'd1024, 2'd0);
        chk("t3_status", 0, 64'(cap_status), 64'd3);
        chk("t3_err", 0, 64'(cap_err), 64'd1);
        chk("t3_valm", 0, cap_valm, 64'd0);
        run(1, 1, 4'd4, 64'd7, 64'd2000, 2'd0);
        chk("t3_lat3_nostall", 1, 64'(cap_stall[0]), 64'd0);
        do_reset();
        run(0, 1, 4'd5, 64'd0, 64'd16, 2'd0);
        chk("t3_array_kept", 0, cap_valm, 64'hDEAD);

        // Error followed by an in-range write
        run(0, 1, 4'd5, 64'd0, 64'd2000, 2'd0);
        run(0, 1, 4'd4, 64'd9, 64'd2, 2'd0);
`ifdef MEM_ERR_STICKY_EN
        chk("t6_status", 0, 64'(cap_status), 64'd3);
`else
        chk("t6_status", 0, 64'(cap_status), 64'd0);
`endif
        do_reset();
        run(0, 1, 4'd5, 64'd0, 64'd2, 2'd0);
`ifdef MEM_ERR_STICKY_EN
        chk("t6_mem2", 0, cap_valm, 64'h22);
`else
        chk("t6_mem2", 0, cap_valm, 64'd9);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
